pe_array_sched: RTL and testbench

Layer-level scheduler for the configurable PE array. Accepts one layer descriptor, then streams global-buffer words onto the shared X-bus with a per-word PE multicast mask:
- filter rows broadcast along each PE row;
- ifmap rows broadcast along anti-diagonals;
- psum words drained from the array to the output sink.

It is the only driver of the array's bus valid, data, tag and mask signals and sits between the global buffer and the PE array.

---
 rtl/pe_array_sched_if.sv | 50 +++++
 rtl/pe_array_sched.sv | 152 +++++++++++++++
 tb/tb_pe_array_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pe_array_sched_if.sv
// Bundle of descriptor, global-buffer, X-bus, psum and sink signals for pe_array_sched.
// master = scheduler side; slave = environment side (global buffer, array, sink).
// Carries no logic; handshake timing is defined by the scheduler.
interface pe_array_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 3,
    parameter int NUM_COL    = 3,
    parameter int CNT_WIDTH  = 8
);
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [CNT_WIDTH-1:0]         cfg_fltr_len;
    logic [CNT_WIDTH-1:0]         cfg_ifmap_len;
    logic [CNT_WIDTH-1:0]         cfg_psum_len;

    logic                         src_valid;
    logic                         src_ready;
    logic [DATA_WIDTH-1:0]        src_data;

    logic                         bus_valid;
    logic                         bus_ready;
    logic [DATA_WIDTH-1:0]        bus_data;
    logic [1:0]                   bus_type;
    logic [NUM_ROW*NUM_COL-1:0]   bus_pe_mask;

    logic                         psum_in_valid;
    logic                         psum_in_ready;
    logic [DATA_WIDTH-1:0]        psum_in_data;

    logic                         dst_valid;
    logic                         dst_ready;
    logic [DATA_WIDTH-1:0]        dst_data;

    logic                         busy;
    logic                         done;

    modport master (
        input  cfg_valid, cfg_fltr_len, cfg_ifmap_len, cfg_psum_len,
        input  src_valid, src_data, bus_ready, psum_in_valid, psum_in_data, dst_ready,
        output cfg_ready, src_ready, bus_valid, bus_data, bus_type, bus_pe_mask,
        output psum_in_ready, dst_valid, dst_data, busy, done
    );

    modport slave (
        output cfg_valid, cfg_fltr_len, cfg_ifmap_len, cfg_psum_len,
        output src_valid, src_data, bus_ready, psum_in_valid, psum_in_data, dst_ready,
        input  cfg_ready, src_ready, bus_valid, bus_data, bus_type, bus_pe_mask,
        input  psum_in_ready, dst_valid, dst_data, busy, done
    );
endinterface

// File: rtl/pe_array_sched.sv
// Layer scheduler: filter rows per PE row, ifmap rows per anti-diagonal, then psum drain.
// Latency: zero-cycle combinational pass-through src->bus and psum->dst; phase change at next cycle.
// Backpressure: bus_ready drives src_ready, dst_ready drives psum_in_ready; stalls hold all counters.
module pe_array_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 3,
    parameter int NUM_COL    = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    pe_array_sched_if.master   io
);
    localparam int NUM_DIAG = NUM_ROW + NUM_COL - 1;
    localparam int GW       = (NUM_DIAG > 1) ? $clog2(NUM_DIAG) : 1;

    localparam logic [CNT_WIDTH-1:0] W_ONE = 1;
    localparam logic [GW-1:0]        G_ONE = 1;
    localparam logic [GW-1:0]        G_ROW_MAX  = GW'(NUM_ROW - 1);
    localparam logic [GW-1:0]        G_DIAG_MAX = GW'(NUM_DIAG - 1);

    typedef enum logic [2:0] {IDLE, FLTR, IFMAP, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] w;
    logic [GW-1:0]        g;
    logic [CNT_WIDTH-1:0] fltr_len, ifmap_len, psum_len;

    logic                 beat;
    logic                 w_last;
    logic                 g_last;
    logic [CNT_WIDTH-1:0] cur_len;
    logic [GW-1:0]        g_max;

    // Earliest phase with work to do, in FLTR -> IFMAP -> DRAIN order.
    function automatic state_t first_phase(input logic [CNT_WIDTH-1:0] f,
                                           input logic [CNT_WIDTH-1:0] i,
                                           input logic [CNT_WIDTH-1:0] p);
        if (f != '0)      return FLTR;
        else if (i != '0) return IFMAP;
        else if (p != '0) return DRAIN;
        else              return DONE;
    endfunction

    // Pass-through data paths; qualified only by the valid signals.
    assign io.bus_data = io.src_data;
    assign io.dst_data = io.psum_in_data;

    // Per-phase word count and group limit used for wrap detection.
    always_comb begin
        cur_len = '0;
        g_max   = '0;
        case (state)
            FLTR:    begin cur_len = fltr_len;  g_max = G_ROW_MAX;  end
            IFMAP:   begin cur_len = ifmap_len; g_max = G_DIAG_MAX; end
            DRAIN:   begin cur_len = psum_len;  end
            default: ;
        endcase
        w_last = (w == cur_len - W_ONE);
        g_last = (g == g_max);
    end

    // Next-state, handshake and multicast mask decode.
    always_comb begin
        state_nxt        = state;
        beat             = 1'b0;
        io.cfg_ready     = 1'b0;
        io.src_ready     = 1'b0;
        io.bus_valid     = 1'b0;
        io.bus_type      = 2'b00;
        io.bus_pe_mask   = '0;
        io.psum_in_ready = 1'b0;
        io.dst_valid     = 1'b0;
        io.busy          = (state != IDLE);
        io.done          = 1'b0;
        case (state)
            IDLE: begin
                io.cfg_ready = 1'b1;
                if (io.cfg_valid)
                    state_nxt = first_phase(io.cfg_fltr_len, io.cfg_ifmap_len, io.cfg_psum_len);
            end
            FLTR: begin
                io.bus_valid = io.src_valid;
                io.src_ready = io.bus_ready;
                io.bus_type  = 2'b01;
                for (int i = 0; i < NUM_ROW; i++)
                    for (int j = 0; j < NUM_COL; j++)
                        io.bus_pe_mask[i*NUM_COL+j] = (i == int'(g));
                beat = io.src_valid && io.bus_ready;
                if (beat && w_last && g_last)
                    state_nxt = first_phase('0, ifmap_len, psum_len);
            end
            IFMAP: begin
                io.bus_valid = io.src_valid;
                io.src_ready = io.bus_ready;
                io.bus_type  = 2'b10;
                for (int i = 0; i < NUM_ROW; i++)
                    for (int j = 0; j < NUM_COL; j++)
                        io.bus_pe_mask[i*NUM_COL+j] = ((i + j) == int'(g));
                beat = io.src_valid && io.bus_ready;
                if (beat && w_last && g_last)
                    state_nxt = first_phase('0, '0, psum_len);
            end
            DRAIN: begin
                io.dst_valid     = io.psum_in_valid;
                io.psum_in_ready = io.dst_ready;
                beat = io.psum_in_valid && io.dst_ready;
                if (beat && w_last)
                    state_nxt = DONE;
            end
            DONE: begin
                io.done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Descriptor latch and word/group counters; counters restart on every phase change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w         <= '0;
            g         <= '0;
            fltr_len  <= '0;
            ifmap_len <= '0;
            psum_len  <= '0;
        end else begin
            if (state == IDLE && io.cfg_valid) begin
                fltr_len  <= io.cfg_fltr_len;
                ifmap_len <= io.cfg_ifmap_len;
                psum_len  <= io.cfg_psum_len;
            end
            if (state_nxt != state) begin
                w <= '0;
                g <= '0;
            end else if (beat) begin
                if (w_last) begin
                    w <= '0;
                    g <= g + G_ONE;
                end else begin
                    w <= w + W_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_array_sched.sv
// Randomized directed bench for pe_array_sched against a queue-based beat model.
module tb_pe_array_sched;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pe_array_sched_if #(.DATA_WIDTH(16), .NUM_ROW(3), .NUM_COL(3), .CNT_WIDTH(8)) io ();

    pe_array_sched #(.DATA_WIDTH(16), .NUM_ROW(3), .NUM_COL(3), .CNT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] t;
        logic [8:0] m;
    } beat_t;

    beat_t      bq[$];
    logic [8:0] row_mask  [3] = '{9'h007, 9'h038, 9'h1C0};
    logic [8:0] diag_mask [5] = '{9'h001, 9'h00A, 9'h054, 9'h0A0, 9'h100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, io.cfg_ready, 1);
        chk({tag, "_busy"}, io.busy, 0);
        chk({tag, "_done"}, io.done, 0);
        chk({tag, "_bus_valid"}, io.bus_valid, 0);
        chk({tag, "_src_ready"}, io.src_ready, 0);
        chk({tag, "_dst_valid"}, io.dst_valid, 0);
        chk({tag, "_psum_in_ready"}, io.psum_in_ready, 0);
        chk({tag, "_bus_type"}, io.bus_type, 0);
        chk({tag, "_mask"}, io.bus_pe_mask, 0);
    endtask

    // Expected ordered beat list for a descriptor, built from the multicast rules.
    task automatic build_model(input int f, input int i);
        beat_t b;
        bq.delete();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < f; k++) begin
                b.t = 2'b01; b.m = row_mask[r]; bq.push_back(b);
            end
        for (int d = 0; d < 5; d++)
            for (int k = 0; k < i; k++) begin
                b.t = 2'b10; b.m = diag_mask[d]; bq.push_back(b);
            end
    endtask

    task automatic run_layer(input int f, input int i, input int p, input bit stall);
        int psum_left;
        bit fin;
        build_model(f, i);
        psum_left = p;
        @(negedge clk);
        io.cfg_valid     = 1'b1;
        io.cfg_fltr_len  = 8'(f);
        io.cfg_ifmap_len = 8'(i);
        io.cfg_psum_len  = 8'(p);
        #1;
        chk("accept_cfg_ready", io.cfg_ready, 1);
        chk("accept_busy", io.busy, 0);
        fin = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            // Descriptor noise while busy must not disturb the running layer.
            io.cfg_valid     = 1'($urandom_range(0, 1));
            io.cfg_fltr_len  = 8'($urandom);
            io.cfg_ifmap_len = 8'($urandom);
            io.cfg_psum_len  = 8'($urandom);
            io.src_valid     = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            io.bus_ready     = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            io.psum_in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            io.dst_ready     = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            io.src_data      = 16'($urandom);
            io.psum_in_data  = 16'($urandom);
            #1;
            if (bq.size() > 0) begin
                chk("bus_valid", io.bus_valid, io.src_valid);
                chk("src_ready", io.src_ready, io.bus_ready);
                chk("dst_valid_in_bus", io.dst_valid, 0);
                chk("psum_rdy_in_bus", io.psum_in_ready, 0);
                chk("busy_bus", io.busy, 1);
                chk("done_bus", io.done, 0);
                if (io.bus_valid) begin
                    chk("bus_type", io.bus_type, bq[0].t);
                    chk("bus_mask", io.bus_pe_mask, bq[0].m);
                    chk("bus_data", io.bus_data, io.src_data);
                end
                if (io.src_valid && io.bus_ready) void'(bq.pop_front());
            end else if (psum_left > 0) begin
                chk("dst_valid", io.dst_valid, io.psum_in_valid);
                chk("psum_in_ready", io.psum_in_ready, io.dst_ready);
                chk("bus_valid_in_drain", io.bus_valid, 0);
                chk("src_ready_in_drain", io.src_ready, 0);
                chk("bus_type_in_drain", io.bus_type, 0);
                chk("mask_in_drain", io.bus_pe_mask, 0);
                chk("done_drain", io.done, 0);
                if (io.dst_valid) chk("dst_data", io.dst_data, io.psum_in_data);
                if (io.psum_in_valid && io.dst_ready) psum_left--;
            end else begin
                chk("done_pulse", io.done, 1);
                chk("done_bus_valid", io.bus_valid, 0);
                chk("done_dst_valid", io.dst_valid, 0);
                chk("done_cfg_ready", io.cfg_ready, 0);
                io.cfg_valid = 1'b0;
                fin = 1'b1;
            end
        end
        if (!fin) chk("timeout", 0, 1);
        @(negedge clk);
        io.cfg_valid = 1'b0;
        #1;
        chk_reset_outputs("back_idle");
    endtask

    initial begin
        rst              = 1'b1;
        io.cfg_valid     = 1'b0;
        io.cfg_fltr_len  = '0;
        io.cfg_ifmap_len = '0;
        io.cfg_psum_len  = '0;
        io.src_valid     = 1'b0;
        io.src_data      = '0;
        io.bus_ready     = 1'b0;
        io.psum_in_valid = 1'b0;
        io.psum_in_data  = '0;
        io.dst_ready     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Filter-only and ifmap-only layers with no stalls.
        run_layer(2, 0, 0, 1'b0);
        run_layer(0, 1, 0, 1'b0);
        // Full layer under random stalls on every handshake.
        run_layer(1, 2, 4, 1'b1);
        // Empty descriptor goes straight to DONE.
        run_layer(0, 0, 0, 1'b0);

        // Reset asserted during the third ifmap beat.
        @(negedge clk);
        io.cfg_valid     = 1'b1;
        io.cfg_fltr_len  = 8'd0;
        io.cfg_ifmap_len = 8'd1;
        io.cfg_psum_len  = 8'd0;
        io.src_valid     = 1'b1;
        io.bus_ready     = 1'b1;
        @(negedge clk);
        io.cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_mask", io.bus_pe_mask, 9'h054);
        chk("pre_reset_valid", io.bus_valid, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        run_layer(1, 0, 0, 1'b0);

        // Random small descriptors with stalls.
        for (int k = 0; k < 5; k++)
            run_layer($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
